frame_window_recycler: RTL and testbench

- Buffers one frame of FRAME_LEN signed column vectors from a valid/ready/last stream.
- Replays the frame NUM_FILTERS times as 3-tap sliding windows (prev, current, next), zero-padded at the frame edges.
- Feeds the vector-multiply/vector-add stage of the 1D convolution datapath, one window per filter pass per position.

---
 rtl/frame_window_recycler_pkg.sv | 18 +
 rtl/frame_window_recycler_frame_buffer.sv | 39 +++
 rtl/frame_window_recycler.sv | 131 +++++++++++++
 tb/tb_frame_window_recycler.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/frame_window_recycler_pkg.sv
// Shared definitions for the 1D convolution datapath.
// BW and FILTER_LEN are also consumed by the vec_mul/vec_add stages.
package frame_window_recycler_pkg;

  localparam int unsigned BW         = 8;
  localparam int unsigned FILTER_LEN = 3;

  typedef enum logic {
    LOAD = 1'b0,
    EMIT = 1'b1
  } fwr_state_t;

  // Address/counter width for a range of n values, never narrower than 1 bit.
  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_window_recycler_frame_buffer.sv
// frame_buffer: DEPTH x WIDTH register array, one synchronous write port and
// three combinational read ports (prev/current/next taps). Not reset.
// Ports:
//   clk_i               clock
//   we_i, waddr_i, wdata_i   write port
//   raddr{0,1,2}_i      read addresses
//   rdata{0,1,2}_o      combinational read data
module frame_buffer
  import frame_window_recycler_pkg::*;
#(
  parameter int unsigned DEPTH = 50,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = addr_w(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr0_i,
  input  logic [AW-1:0]    raddr1_i,
  input  logic [AW-1:0]    raddr2_i,
  output logic [WIDTH-1:0] rdata0_o,
  output logic [WIDTH-1:0] rdata1_o,
  output logic [WIDTH-1:0] rdata2_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata0_o = mem[raddr0_i];
  assign rdata1_o = mem[raddr1_i];
  assign rdata2_o = mem[raddr2_i];

endmodule

// File: rtl/frame_window_recycler.sv
// frame_window_recycler: buffers one frame of FRAME_LEN column vectors from a
// valid/ready stream, then replays it NUM_FILTERS times as 3-tap windows
// (x[t-1], x[t], x[t+1]) with zero padding at the frame edges.
// Ports:
//   clk_i, rst_i (async, active-high)
//   data_i/valid_i/last_i/ready_o     input column stream (last_i informational)
//   data0_o/data1_o/data2_o           window taps prev/current/next
//   valid_o/last_o/ready_i            window stream, last_o on final window of final pass
module frame_window_recycler #(
  parameter int unsigned BW          = frame_window_recycler_pkg::BW,
  parameter int unsigned FRAME_LEN   = 50,
  parameter int unsigned COLUMN_LEN  = 1,
  parameter int unsigned NUM_FILTERS = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [COLUMN_LEN*BW-1:0]   data_i,
  input  logic                       valid_i,
  input  logic                       last_i,
  output logic                       ready_o,
  output logic [COLUMN_LEN*BW-1:0]   data0_o,
  output logic [COLUMN_LEN*BW-1:0]   data1_o,
  output logic [COLUMN_LEN*BW-1:0]   data2_o,
  output logic                       valid_o,
  output logic                       last_o,
  input  logic                       ready_i
);

  import frame_window_recycler_pkg::*;

  localparam int unsigned VECTOR_BW = COLUMN_LEN * BW;
  localparam int unsigned AW        = addr_w(FRAME_LEN);
  localparam int unsigned PW        = addr_w(NUM_FILTERS);

  localparam logic [AW-1:0] LAST_POS  = AW'(FRAME_LEN - 1);
  localparam logic [PW-1:0] LAST_PASS = PW'(NUM_FILTERS - 1);

  fwr_state_t      state;
  logic [AW-1:0]   wr_cnt;
  logic [AW-1:0]   pos;
  logic [PW-1:0]   pass;

  logic            we;
  logic [AW-1:0]   prev_addr;
  logic [AW-1:0]   next_addr;
  logic [VECTOR_BW-1:0] rd_prev, rd_cur, rd_next;

  // Frame length is fixed by FRAME_LEN; the marker is carried but not acted on.
  logic last_unused;
  assign last_unused = last_i;

  assign ready_o = (state == LOAD) && !rst_i;
  assign we      = (state == LOAD) && valid_i && ready_o;

  // Edge addresses are clamped into range; the taps are zeroed below instead.
  assign prev_addr = (pos == '0)       ? '0  : pos - AW'(1);
  assign next_addr = (pos == LAST_POS) ? pos : pos + AW'(1);

  frame_buffer #(
    .DEPTH (FRAME_LEN),
    .WIDTH (VECTOR_BW),
    .AW    (AW)
  ) u_frame_buffer (
    .clk_i    (clk_i),
    .we_i     (we),
    .waddr_i  (wr_cnt),
    .wdata_i  (data_i),
    .raddr0_i (prev_addr),
    .raddr1_i (pos),
    .raddr2_i (next_addr),
    .rdata0_o (rd_prev),
    .rdata1_o (rd_cur),
    .rdata2_o (rd_next)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= LOAD;
      wr_cnt <= '0;
      pos    <= '0;
      pass   <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (we) begin
            if (wr_cnt == LAST_POS) begin
              wr_cnt <= '0;
              state  <= EMIT;
            end else begin
              wr_cnt <= wr_cnt + AW'(1);
            end
          end
        end
        EMIT: begin
          if (ready_i) begin
            if (pos == LAST_POS) begin
              pos <= '0;
              if (pass == LAST_PASS) begin
                pass  <= '0;
                state <= LOAD;
              end else begin
                pass <= pass + PW'(1);
              end
            end else begin
              pos <= pos + AW'(1);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Window outputs are combinational so a stalled window is held by simply
  // not moving pos/pass; async reset forces state to LOAD and drops valid_o.
  always_comb begin
    valid_o = 1'b0;
    last_o  = 1'b0;
    data0_o = '0;
    data1_o = '0;
    data2_o = '0;
    if (state == EMIT) begin
      valid_o = 1'b1;
      last_o  = (pos == LAST_POS) && (pass == LAST_PASS);
      data0_o = (pos == '0)       ? '0 : rd_prev;
      data1_o = rd_cur;
      data2_o = (pos == LAST_POS) ? '0 : rd_next;
    end
  end

endmodule

// File: tb/tb_frame_window_recycler.sv
module tb_frame_window_recycler;

  localparam int FL = 4;
  localparam int NF = 2;
  localparam int VW = 16;

  typedef struct packed {
    logic [VW-1:0] d0;
    logic [VW-1:0] d1;
    logic [VW-1:0] d2;
    logic          last;
  } win_t;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic [VW-1:0] data_i = '0;
  logic          valid_i = 1'b0;
  logic          last_i = 1'b0;
  logic          ready_o;
  logic [VW-1:0] data0_o, data1_o, data2_o;
  logic          valid_o, last_o;
  logic          ready_i = 1'b0;

  int unsigned checks = 0;
  int unsigned passes = 0;

  logic [VW-1:0] load_q[$];
  win_t          exp_q[$];
  win_t          log_q[$];

  frame_window_recycler #(
    .BW          (8),
    .FRAME_LEN   (FL),
    .COLUMN_LEN  (2),
    .NUM_FILTERS (NF)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .data_i  (data_i),
    .valid_i (valid_i),
    .last_i  (last_i),
    .ready_o (ready_o),
    .data0_o (data0_o),
    .data1_o (data1_o),
    .data2_o (data2_o),
    .valid_o (valid_o),
    .last_o  (last_o),
    .ready_i (ready_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
  endtask

  // lane0 = v, lane1 = -v saturated to 8-bit signed
  function automatic logic [VW-1:0] pk(input int v);
    int n;
    logic [7:0] l0, l1;
    n = -v;
    if (n > 127) n = 127;
    l0 = 8'(v);
    l1 = 8'(n);
    return {l1, l0};
  endfunction

  // Behavioural model: frame collected as a list; once complete it expands
  // into the full list of expected windows, consumed one per handshake.
  always @(negedge clk) begin
    win_t obs;
    obs = {data0_o, data1_o, data2_o, last_o};
    if (rst_i) begin
      chk("rst_ready", 64'(ready_o), 64'd0);
      chk("rst_valid", 64'(valid_o), 64'd0);
      chk("rst_window", 64'(obs), 64'd0);
      load_q.delete();
      exp_q.delete();
    end else if (exp_q.size() == 0) begin
      chk("load_ready", 64'(ready_o), 64'd1);
      chk("load_valid", 64'(valid_o), 64'd0);
      chk("load_window", 64'(obs), 64'd0);
      if (valid_i) begin
        load_q.push_back(data_i);
        if (load_q.size() == FL) begin
          for (int ps = 0; ps < NF; ps++) begin
            for (int p = 0; p < FL; p++) begin
              win_t w;
              w.d0   = '0;
              w.d2   = '0;
              if (p > 0) w.d0 = load_q[p-1];
              w.d1   = load_q[p];
              if (p < FL-1) w.d2 = load_q[p+1];
              w.last = (ps == NF-1) && (p == FL-1);
              exp_q.push_back(w);
            end
          end
          load_q.delete();
        end
      end
    end else begin
      chk("emit_ready", 64'(ready_o), 64'd0);
      chk("emit_valid", 64'(valid_o), 64'd1);
      chk("emit_window", 64'(obs), 64'(exp_q[0]));
      if (ready_i) begin
        log_q.push_back(obs);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic load_frame(input int v0, input int v1, input int v2, input int v3, input bit gap);
    int v[4];
    v = '{v0, v1, v2, v3};
    for (int i = 0; i < 4; i++) begin
      valid_i = 1'b1;
      data_i  = pk(v[i]);
      last_i  = (i == 3);
      @(posedge clk); #1;
      valid_i = 1'b0;
      last_i  = 1'b0;
      if (gap && i < 3) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic run_emit(input bit toggle);
    int unsigned n;
    n = 0;
    ready_i = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      if (toggle) ready_i = ~ready_i;
      n++;
    end
    chk("emit_timeout", 64'(n < 200), 64'd1);
    ready_i = 1'b1;
  endtask

  function automatic int count_last();
    int c;
    c = 0;
    foreach (log_q[i]) if (log_q[i].last) c++;
    return c;
  endfunction

  initial begin
    int unsigned n;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    #3;
    chk("post_reset_ready", 64'(ready_o), 64'd1);
    chk("post_reset_valid", 64'(valid_o), 64'd0);
    chk("post_reset_data", 64'({data0_o, data1_o, data2_o}), 64'd0);
    @(posedge clk); #1;

    // basic frame, ready_i held high
    log_q.delete();
    ready_i = 1'b1;
    load_frame(1, 2, 3, 4, 1'b0);
    run_emit(1'b0);
    chk("basic_count", 64'(log_q.size()), 64'd8);
    chk("basic_w0", 64'(log_q[0]), 64'({16'h0000, 16'hFF01, 16'hFE02, 1'b0}));
    chk("basic_w3", 64'(log_q[3]), 64'({16'hFD03, 16'hFC04, 16'h0000, 1'b0}));
    chk("basic_w7", 64'(log_q[7]), 64'({16'hFD03, 16'hFC04, 16'h0000, 1'b1}));
    chk("basic_last_cnt", 64'(count_last()), 64'd1);
    #3 chk("basic_ready_after", 64'(ready_o), 64'd1);
    @(posedge clk); #1;

    // downstream backpressure
    log_q.delete();
    load_frame(1, 2, 3, 4, 1'b0);
    run_emit(1'b1);
    chk("bp_count", 64'(log_q.size()), 64'd8);
    chk("bp_w1", 64'(log_q[1]), 64'({16'hFF01, 16'hFE02, 16'hFD03, 1'b0}));
    chk("bp_w4", 64'(log_q[4]), 64'({16'h0000, 16'hFF01, 16'hFE02, 1'b0}));

    // signed lanes with saturation
    log_q.delete();
    load_frame(-128, -1, 127, 5, 1'b0);
    run_emit(1'b0);
    chk("sgn_w0", 64'(log_q[0]), 64'({16'h0000, 16'h7F80, 16'h01FF, 1'b0}));
    chk("sgn_w7", 64'(log_q[7]), 64'({16'h817F, 16'hFB05, 16'h0000, 1'b1}));

    // sparse input beats, then stray beats offered during emit
    log_q.delete();
    load_frame(9, 10, 11, 12, 1'b1);
    valid_i = 1'b1;
    data_i  = pk(99);
    repeat (4) begin
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    run_emit(1'b0);
    chk("sparse_count", 64'(log_q.size()), 64'd8);
    chk("sparse_w2", 64'(log_q[2]), 64'({pk(10), pk(11), pk(12), 1'b0}));

    // async reset during the 3rd window, then reload
    log_q.delete();
    load_frame(1, 2, 3, 4, 1'b0);
    ready_i = 1'b1;
    n = 0;
    while (log_q.size() < 2 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rst_wait_timeout", 64'(n < 50), 64'd1);
    chk("pre_rst_w2", 64'({data0_o, data1_o, data2_o}), 64'({16'hFE02, 16'hFD03, 16'hFC04}));
    #2 rst_i = 1'b1;
    #1;
    chk("async_valid_drop", 64'(valid_o), 64'd0);
    chk("async_ready_drop", 64'(ready_o), 64'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    log_q.delete();
    @(posedge clk); #1;
    load_frame(5, 6, 7, 8, 1'b0);
    run_emit(1'b0);
    chk("reload_count", 64'(log_q.size()), 64'd8);
    chk("reload_w0", 64'(log_q[0]), 64'({16'h0000, 16'hFB05, 16'hFA06, 1'b0}));
    chk("reload_w7", 64'(log_q[7]), 64'({16'hF907, 16'hF808, 16'h0000, 1'b1}));

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
